// File: rtl/vpu_ialu_seq_if.sv
// Issue, operand and result channels of the VPU integer ALU sequencer.
// The sequencer sits on the slave side; the instruction source and the
// result consumer sit on the master side.
interface vpu_ialu_seq_if #(
    parameter int LANES = 4,
    parameter int VLW   = 6
);
    // Instruction issue channel
    logic                  iss_valid;
    logic                  iss_ready;
    logic [3:0]            iss_op;
    logic [VLW-1:0]        iss_vl;
    logic                  iss_vec;
    logic [15:0]           iss_scalar;

    // Operand beat channel
    logic                  opd_valid;
    logic                  opd_ready;
    logic [LANES*16-1:0]   opd_ds1;
    logic [LANES*16-1:0]   opd_ds2;

    // Result beat channel
    logic                  res_valid;
    logic                  res_ready;
    logic [LANES*16-1:0]   res_data;
    logic [LANES-1:0]      res_lmask;
    logic                  res_last;

    modport slave (
        input  iss_valid, iss_op, iss_vl, iss_vec, iss_scalar,
        output iss_ready,
        input  opd_valid, opd_ds1, opd_ds2,
        output opd_ready,
        output res_valid, res_data, res_lmask, res_last,
        input  res_ready
    );

    modport master (
        output iss_valid, iss_op, iss_vl, iss_vec, iss_scalar,
        input  iss_ready,
        output opd_valid, opd_ds1, opd_ds2,
        input  opd_ready,
        input  res_valid, res_data, res_lmask, res_last,
        output res_ready
    );
endinterface

// File: rtl/vpu_ialu_seq.sv
// Issue sequencer for the per-lane 16-bit VPU integer ALUs.
// One instruction at a time: operand beats flow through a register stage
// feeding the lane ALUs (stage1) and a result register stage (stage2).
// Per-element gt/eq flags from enabled lanes are gathered into compare masks.
module vpu_ialu_seq #(
    parameter int LANES = 4,
    parameter int VLMAX = 32,
    parameter int VLW   = 6
) (
    input  logic                  clk,
    input  logic                  rst,        // asynchronous, active low
    vpu_ialu_seq_if.slave         bus,
    output logic                  alu_vec_en,
    output logic [LANES-1:0]      alu_enable,
    output logic [9:0]            alu_sel,
    output logic [LANES*16-1:0]   alu_ds1,
    output logic [LANES*16-1:0]   alu_rs,
    output logic [15:0]           alu_ds2,
    input  logic [LANES*16-1:0]   alu_rd,
    input  logic [LANES-1:0]      alu_gt,
    input  logic [LANES-1:0]      alu_eq,
    output logic [VLMAX-1:0]      cmp_gt,
    output logic [VLMAX-1:0]      cmp_eq,
    output logic                  done,
    output logic                  err
);
    // One extra bit so element indices past the last beat never wrap.
    localparam int EW = VLW + 1;
    localparam int LW = $clog2(LANES);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERR} state_t;

    state_t                state_reg, state_next;
    logic                  iss_ready_int;

    logic [3:0]            op_reg;
    logic [VLW-1:0]        vl_reg;
    logic                  vec_reg;
    logic [15:0]           scalar_reg;
    logic [VLW-1:0]        beat_reg;      // index of the next operand beat

    logic                  s1_valid_reg;
    logic                  s1_last_reg;
    logic [VLW-1:0]        s1_beat_reg;

    logic                  res_valid_reg;
    logic [LANES*16-1:0]   res_data_reg;
    logic [LANES-1:0]      res_lmask_reg;
    logic                  res_last_reg;

    logic [EW-1:0]         beats;
    logic                  last_opd;
    logic                  iss_fire;
    logic                  opd_ready_int;
    logic                  opd_fire;
    logic                  s2_load;
    logic [LANES-1:0]      lane_en;
    logic [9:0]            sel_dec;
    logic [VLMAX-1:0]      mask_hit;
    logic [VLMAX-1:0]      gt_spread;
    logic [VLMAX-1:0]      eq_spread;

    // Beat count is vl rounded up to whole beats.
    assign beats    = (EW'(vl_reg) + EW'(LANES - 1)) >> LW;
    assign last_opd = (EW'(beat_reg) == (beats - EW'(1)));

    assign iss_fire      = bus.iss_valid & iss_ready_int;
    // Stage2 takes stage1 whenever it is empty or being drained this cycle.
    assign s2_load       = s1_valid_reg & (~res_valid_reg | bus.res_ready);
    assign opd_ready_int = (state_reg == RUN) & (EW'(beat_reg) < beats)
                         & (~s1_valid_reg | s2_load);
    assign opd_fire      = bus.opd_valid & opd_ready_int;

    assign bus.iss_ready = iss_ready_int;
    assign bus.opd_ready = opd_ready_int;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_data  = res_data_reg;
    assign bus.res_lmask = res_lmask_reg;
    assign bus.res_last  = res_last_reg;

    // Lane k of the current beat carries element beat*LANES+k.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_en[gi] = (EW'(beat_reg) * EW'(LANES) + EW'(gi)) < EW'(vl_reg);
        end
        for (gi = 0; gi < VLMAX; gi++) begin : g_mask
            assign mask_hit[gi]  = s2_load & alu_enable[gi % LANES]
                                 & (s1_beat_reg == VLW'(gi / LANES));
            assign gt_spread[gi] = alu_gt[gi % LANES];
            assign eq_spread[gi] = alu_eq[gi % LANES];
        end
    endgenerate

    // Opcode to one-hot ALU select; pass and cmp leave every select low.
    always_comb begin
        sel_dec = '0;
        if (op_reg >= 4'd1 && op_reg <= 4'd10) begin
            sel_dec = 10'd1 << (op_reg - 4'd1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and status outputs.
    always_comb begin
        state_next    = state_reg;
        iss_ready_int = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (state_reg)
            IDLE: begin
                iss_ready_int = 1'b1;
                if (bus.iss_valid) begin
                    if (bus.iss_op > 4'd11) begin
                        state_next = ERR;
                    end else if (bus.iss_vl == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (opd_fire && last_opd) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (res_valid_reg && bus.res_ready && res_last_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                done       = 1'b1;
                err        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Instruction latch and operand beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg     <= '0;
            vl_reg     <= '0;
            vec_reg    <= 1'b0;
            scalar_reg <= '0;
            beat_reg   <= '0;
        end else if (iss_fire) begin
            op_reg     <= bus.iss_op;
            vl_reg     <= bus.iss_vl;
            vec_reg    <= bus.iss_vec;
            scalar_reg <= bus.iss_scalar;
            beat_reg   <= '0;
        end else if (opd_fire) begin
            beat_reg   <= beat_reg + VLW'(1);
        end
    end

    // Stage1: lane operands and controls presented to the ALUs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_beat_reg  <= '0;
            alu_vec_en   <= 1'b0;
            alu_enable   <= '0;
            alu_sel      <= '0;
            alu_ds1      <= '0;
            alu_rs       <= '0;
            alu_ds2      <= '0;
        end else if (opd_fire) begin
            s1_valid_reg <= 1'b1;
            s1_last_reg  <= last_opd;
            s1_beat_reg  <= beat_reg;
            alu_vec_en   <= vec_reg;
            alu_enable   <= lane_en;
            alu_sel      <= (lane_en != '0) ? sel_dec : '0;
            alu_ds1      <= bus.opd_ds1;
            alu_rs       <= bus.opd_ds2;
            alu_ds2      <= scalar_reg;
        end else if (s2_load) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Stage2: result beat held until the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_lmask_reg <= '0;
            res_last_reg  <= 1'b0;
        end else if (s2_load) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= alu_rd;
            res_lmask_reg <= alu_enable;
            res_last_reg  <= s1_last_reg;
        end else if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
        end
    end

    // Compare masks: cleared on issue, filled as enabled lanes reach stage2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_gt <= '0;
            cmp_eq <= '0;
        end else if (iss_fire) begin
            cmp_gt <= '0;
            cmp_eq <= '0;
        end else begin
            cmp_gt <= (cmp_gt & ~mask_hit) | (gt_spread & mask_hit);
            cmp_eq <= (cmp_eq & ~mask_hit) | (eq_spread & mask_hit);
        end
    end
endmodule

// File: tb/tb_vpu_ialu_seq.sv
// Self-checking bench for vpu_ialu_seq: directed cases, backpressure,
// illegal op, zero length, mid-run reset, then random instructions with a
// scoreboard of expected result beats checked by an independent monitor.
module tb_vpu_ialu_seq;
    localparam int LANES = 4;
    localparam int VLMAX = 32;
    localparam int VLW   = 6;

    typedef struct packed {
        logic [LANES*16-1:0] data;
        logic [LANES-1:0]    lmask;
        logic                last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  alu_vec_en;
    logic [LANES-1:0]      alu_enable;
    logic [9:0]            alu_sel;
    logic [LANES*16-1:0]   alu_ds1, alu_rs, alu_rd;
    logic [15:0]           alu_ds2;
    logic [LANES-1:0]      alu_gt, alu_eq;
    logic [VLMAX-1:0]      cmp_gt, cmp_eq;
    logic                  done, err;

    int n_vec = 0;
    int n_bad = 0;
    int n_res = 0;
    int cyc   = 0;
    int first_opd_cyc, first_res_cyc;
    bit lat_armed = 0;
    bit rand_bp   = 0;

    beat_t          sb[$];
    beat_t          mon_e;
    logic [15:0]    ds1_el [VLMAX];
    logic [15:0]    ds2_el [VLMAX];
    logic [VLMAX-1:0] exp_gt, exp_eq;
    logic [15:0]    la, lb, lr;

    always #5 clk = ~clk;

    vpu_ialu_seq_if #(.LANES(LANES), .VLW(VLW)) bus();

    vpu_ialu_seq #(.LANES(LANES), .VLMAX(VLMAX), .VLW(VLW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_vec_en (alu_vec_en),
        .alu_enable (alu_enable),
        .alu_sel    (alu_sel),
        .alu_ds1    (alu_ds1),
        .alu_rs     (alu_rs),
        .alu_ds2    (alu_ds2),
        .alu_rd     (alu_rd),
        .alu_gt     (alu_gt),
        .alu_eq     (alu_eq),
        .cmp_gt     (cmp_gt),
        .cmp_eq     (cmp_eq),
        .done       (done),
        .err        (err)
    );

    // Lane ALUs attached to the sequencer: combinational from its registers.
    always_comb begin
        alu_rd = '0;
        alu_gt = '0;
        alu_eq = '0;
        la = '0;
        lb = '0;
        lr = '0;
        for (int k = 0; k < LANES; k++) begin
            la = alu_ds1[k*16 +: 16];
            lb = alu_vec_en ? alu_rs[k*16 +: 16] : alu_ds2;
            lr = la;
            if (alu_enable[k]) begin
                case (alu_sel)
                    10'b0000000001: lr = la + lb;
                    10'b0000000010: lr = la - lb;
                    10'b0000000100: lr = la & lb;
                    10'b0000001000: lr = la | lb;
                    10'b0000010000: lr = la ^ lb;
                    10'b0000100000: lr = la << lb[3:0];
                    10'b0001000000: lr = la >> lb[3:0];
                    10'b0010000000: lr = $signed(la) >>> lb[3:0];
                    10'b0100000000: lr = ($signed(la) > $signed(lb)) ? la : lb;
                    10'b1000000000: lr = ($signed(la) < $signed(lb)) ? la : lb;
                    default:        lr = la;
                endcase
            end
            alu_rd[k*16 +: 16] = lr;
            alu_gt[k] = $signed(la) > $signed(lb);
            alu_eq[k] = (la == lb);
        end
    end

    // Reference semantics of each opcode on one element.
    function automatic logic [15:0] ref_res(input logic [3:0] op, input logic [15:0] x,
                                            input logic [15:0] y);
        logic signed [15:0] xs, ys;
        xs = x;
        ys = y;
        case (op)
            4'd1:    return x + y;
            4'd2:    return x - y;
            4'd3:    return x & y;
            4'd4:    return x | y;
            4'd5:    return x ^ y;
            4'd6:    return x << y[3:0];
            4'd7:    return x >> y[3:0];
            4'd8:    return xs >>> y[3:0];
            4'd9:    return (xs > ys) ? x : y;
            4'd10:   return (xs < ys) ? x : y;
            default: return x;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_msg(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got timeout expected response", nm);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pops an expected beat for every result handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.res_valid) begin
                if (lat_armed) begin
                    first_res_cyc = cyc;
                    lat_armed = 0;
                end
                if (bus.res_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL sb_underflow: got beat %h expected none", bus.res_data);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("res_data", bus.res_data, mon_e.data);
                        chk("res_lmask", bus.res_lmask, mon_e.lmask);
                        chk("res_last", bus.res_last, mon_e.last);
                    end
                    n_res++;
                end
            end
        end
    end

    // Random result backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) bus.res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    // Expected result beats and compare masks for one instruction.
    task automatic prep_expect(input logic [3:0] op, input int vl, input logic vec,
                               input logic [15:0] sc);
        beat_t e;
        int nb;
        logic [15:0] x, y;
        nb = (vl + LANES - 1) / LANES;
        exp_gt = '0;
        exp_eq = '0;
        for (int b = 0; b < nb; b++) begin
            e.data  = '0;
            e.lmask = '0;
            e.last  = (b == nb - 1);
            for (int k = 0; k < LANES; k++) begin
                int i;
                i = b * LANES + k;
                x = ds1_el[i];
                y = vec ? ds2_el[i] : sc;
                if (i < vl) begin
                    e.data[k*16 +: 16] = ref_res(op, x, y);
                    e.lmask[k] = 1'b1;
                    exp_gt[i] = $signed(x) > $signed(y);
                    exp_eq[i] = (x == y);
                end else begin
                    e.data[k*16 +: 16] = x;
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [3:0] op, input int vl, input logic vec,
                         input logic [15:0] sc);
        int n;
        bus.iss_valid  = 1'b1;
        bus.iss_op     = op;
        bus.iss_vl     = VLW'(vl);
        bus.iss_vec    = vec;
        bus.iss_scalar = sc;
        n = 0;
        @(negedge clk);
        while (!bus.iss_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.iss_ready) fail_msg("iss_timeout");
        @(posedge clk);
        #1;
        bus.iss_valid = 1'b0;
    endtask

    task automatic send_beat(input int b, input bit gaps, output bit ok);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        for (int k = 0; k < LANES; k++) begin
            bus.opd_ds1[k*16 +: 16] = ds1_el[b*LANES + k];
            bus.opd_ds2[k*16 +: 16] = ds2_el[b*LANES + k];
        end
        bus.opd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.opd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = bus.opd_ready;
        if (!ok) fail_msg("opd_timeout");
        else if (b == 0) first_opd_cyc = cyc;
        @(posedge clk);
        #1;
        bus.opd_valid = 1'b0;
    endtask

    task automatic run_instr(input logic [3:0] op, input int vl, input logic vec,
                             input logic [15:0] sc, input bit gaps);
        bit ok;
        int n;
        int nb;
        $display("instr op=%0d vl=%0d vec=%0d scalar=%h", op, vl, vec, sc);
        prep_expect(op, vl, vec, sc);
        first_opd_cyc = -1;
        first_res_cyc = -1;
        lat_armed = (vl > 0);
        issue(op, vl, vec, sc);
        nb = (vl + LANES - 1) / LANES;
        ok = 1;
        for (int b = 0; b < nb && ok; b++) send_beat(b, gaps, ok);
        n = 0;
        @(negedge clk);
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            fail_msg("done_timeout");
        end else begin
            chk("err_on_done", err, 1'b0);
            if (vl > 0) begin
                chk("cmp_gt", cmp_gt, exp_gt);
                chk("cmp_eq", cmp_eq, exp_eq);
                chk("latency", first_res_cyc - first_opd_cyc, 2);
            end
            chk("sb_empty", sb.size(), 0);
        end
        sb.delete();
        lat_armed = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic bad_issue(input logic [3:0] op, input int vl, input logic exp_err);
        $display("instr op=%0d vl=%0d (no beats)", op, vl);
        issue(op, vl, 1'b0, 16'h0);
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("err_pulse", err, exp_err);
        chk("no_opd_ready", bus.opd_ready, 1'b0);
        @(negedge clk);
        chk("done_clear", done, 1'b0);
        chk("err_clear", err, 1'b0);
        chk("iss_ready_back", bus.iss_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        $display("reset check %s", tag);
        chk("rst_iss_ready", bus.iss_ready, 1'b1);
        chk("rst_opd_ready", bus.opd_ready, 1'b0);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_data", bus.res_data, '0);
        chk("rst_res_lmask", bus.res_lmask, '0);
        chk("rst_res_last", bus.res_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_cmp_gt", cmp_gt, '0);
        chk("rst_cmp_eq", cmp_eq, '0);
        chk("rst_alu_enable", alu_enable, '0);
        chk("rst_alu_sel", alu_sel, '0);
        chk("rst_alu_ds1", alu_ds1, '0);
        chk("rst_alu_vec_en", alu_vec_en, 1'b0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < VLMAX; i++) begin
            ds1_el[i] = 16'($urandom);
            ds2_el[i] = ($urandom_range(0, 3) == 0) ? ds1_el[i] : 16'($urandom);
        end
    endtask

    initial begin
        bit ok;
        bus.iss_valid  = 1'b0;
        bus.iss_op     = '0;
        bus.iss_vl     = '0;
        bus.iss_vec    = 1'b0;
        bus.iss_scalar = '0;
        bus.opd_valid  = 1'b0;
        bus.opd_ds1    = '0;
        bus.opd_ds2    = '0;
        bus.res_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("initial");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // add, vector ds2, vl=8: lane k of beat b = 100 + 2*(4b+k)
        for (int i = 0; i < VLMAX; i++) begin
            ds1_el[i] = 16'(i);
            ds2_el[i] = 16'(100 + i);
        end
        run_instr(4'd1, 8, 1'b1, 16'h0, 1'b0);

        // sub scalar 5, vl=6: second beat carries only lanes 0,1
        fill_random();
        run_instr(4'd2, 6, 1'b0, 16'd5, 1'b0);

        // cmp against scalar 3
        ds1_el[0] = 16'hFFFF;
        ds1_el[1] = 16'd3;
        ds1_el[2] = 16'd7;
        ds1_el[3] = 16'd0;
        run_instr(4'd11, 4, 1'b0, 16'd3, 1'b0);
        chk("cmp_gt_dir", cmp_gt, 64'h4);
        chk("cmp_eq_dir", cmp_eq, 64'h2);

        // add vl=32 with a 5-cycle result stall in the middle
        fill_random();
        fork
            run_instr(4'd1, 32, 1'b1, 16'h0, 1'b0);
            begin : stall_blk
                int base;
                int n;
                base = n_res;
                n = 0;
                while (n_res < base + 3 && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                bus.res_ready = 1'b0;
                repeat (5) @(negedge clk);
                chk("opd_ready_stall", bus.opd_ready, 1'b0);
                @(posedge clk);
                #1;
                bus.res_ready = 1'b1;
            end
        join

        // illegal opcode and zero length
        bad_issue(4'd13, 8, 1'b1);
        bad_issue(4'd1, 0, 1'b0);

        // reset while the fourth operand beat is being presented
        $display("instr op=1 vl=32 vec=1 (reset mid-run)");
        fill_random();
        prep_expect(4'd1, 32, 1'b1, 16'h0);
        issue(4'd1, 32, 1'b1, 16'h0);
        ok = 1;
        for (int b = 0; b < 3 && ok; b++) send_beat(b, 1'b0, ok);
        bus.opd_valid = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_reset("mid_run");
        bus.opd_valid = 1'b0;
        sb.delete();
        lat_armed = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // random instructions with operand gaps and result backpressure
        rand_bp = 1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                bad_issue(4'($urandom_range(12, 15)), $urandom_range(0, VLMAX), 1'b1);
            end else begin
                fill_random();
                run_instr(4'($urandom_range(0, 11)), $urandom_range(0, VLMAX),
                          1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
            end
        end
        rand_bp = 0;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
